// File: rtl/mult_seq_pkg.sv
// Shared types and helpers for the sequential shift-add multiplier.
package mult_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    // Counter must reach WIDTH-1 and leave headroom for the increment.
    function automatic int cnt_w(input int width);
        return $clog2(width) + 1;
    endfunction

endpackage

// File: rtl/adder_nbit.sv
// Plain WIDTH-bit adder; carry out is discarded, so the sum wraps modulo 2^WIDTH.
module adder_nbit #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] sum
);

    assign sum = a + b;

endmodule

// File: rtl/multiplier_seq_ctrl.sv
// Shift-add multiplier producing the low WIDTH bits of a*b, one adder step per clock.
// Define MULT_SEQ_EARLY_TERM_EN to finish as soon as the remaining multiplier bits are zero.
module multiplier_seq_ctrl
    import mult_seq_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_p,
    output logic             busy
);

    localparam int CNT_W = cnt_w(WIDTH);

    state_t           state, state_nxt;
    logic [WIDTH-1:0] a_reg, b_reg, acc;
    logic [WIDTH-1:0] addend, sum;
    logic [CNT_W-1:0] cnt;
    logic             last;

    assign addend = b_reg[0] ? a_reg : '0;

    adder_nbit #(.WIDTH(WIDTH)) u_adder (
        .a   (addend),
        .b   (acc),
        .sum (sum)
    );

`ifdef MULT_SEQ_EARLY_TERM_EN
    // No set bits left above bit 0: later steps would only add zero.
    assign last = ((b_reg >> 1) == '0) || (cnt == CNT_W'(WIDTH - 1));
`else
    assign last = (cnt == CNT_W'(WIDTH - 1));
`endif

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        unique case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_nxt = BUSY;
            end
            BUSY: begin
                busy = 1'b1;
                if (last) state_nxt = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_reg <= '0;
            b_reg <= '0;
            acc   <= '0;
            cnt   <= '0;
            out_p <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_reg <= in_a;
                        b_reg <= in_b;
                        acc   <= '0;
                        cnt   <= '0;
                    end
                end
                BUSY: begin
                    acc   <= sum;
                    a_reg <= a_reg << 1;
                    b_reg <= b_reg >> 1;
                    cnt   <= cnt + 1'b1;
                    if (last) out_p <= sum;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_multiplier_seq_ctrl.sv
// Directed-vector and random bench for multiplier_seq_ctrl at WIDTH=8.
module tb_multiplier_seq_ctrl;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_a, in_b;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_p;
    logic         busy;

    int checks = 0;
    int errors = 0;

    multiplier_seq_ctrl #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_p     (out_p),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] p;
    } vec_t;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int exp_busy(input logic [W-1:0] b);
`ifdef MULT_SEQ_EARLY_TERM_EN
        int h = 0;
        for (int i = 0; i < W; i++) if (b[i]) h = i;
        return h + 1;
`else
        return W;
`endif
    endfunction

    task automatic wait_ready();
        int n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("in_ready_wait", int'(in_ready), 1);
    endtask

    // Returns number of BUSY cycles observed after acceptance.
    task automatic start_and_run(input logic [W-1:0] a, input logic [W-1:0] b, output int n);
        wait_ready();
        in_valid = 1'b1;
        in_a = a;
        in_b = b;
        @(negedge clk);
        in_valid = 1'b0;
        in_a = W'($urandom);
        in_b = W'($urandom);
        check("accept_busy", int'(busy), 1);
        check("accept_in_ready", int'(in_ready), 0);
        n = 0;
        while (busy && n < 64) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] p, input int stall);
        int n;
        out_ready = (stall == 0);
        start_and_run(a, b, n);
        check("busy_cycles", n, exp_busy(b));
        check("out_valid", int'(out_valid), 1);
        check("out_p", int'(out_p), int'(p));
        repeat (stall) begin
            @(negedge clk);
            check("stall_valid", int'(out_valid), 1);
            check("stall_p", int'(out_p), int'(p));
        end
        out_ready = 1'b1;
        @(negedge clk);
        check("handoff_in_ready", int'(in_ready), 1);
        check("handoff_out_valid", int'(out_valid), 0);
        check("hold_last_p", int'(out_p), int'(p));
        out_ready = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[13];
        int   n;
        logic [W-1:0] ra, rb, rp;

        vecs[0]  = '{8'd13,  8'd11,  8'h8F};
        vecs[1]  = '{8'd255, 8'd255, 8'h01};
        vecs[2]  = '{8'd16,  8'd16,  8'h00};
        vecs[3]  = '{8'd0,   8'd200, 8'h00};
        vecs[4]  = '{8'd200, 8'd0,   8'h00};
        vecs[5]  = '{8'd7,   8'd9,   8'h3F};
        vecs[6]  = '{8'd100, 8'd3,   8'h2C};
        vecs[7]  = '{8'd1,   8'd255, 8'hFF};
        vecs[8]  = '{8'd3,   8'h80,  8'h80};
        vecs[9]  = '{8'd2,   8'h80,  8'h00};
        vecs[10] = '{8'd5,   8'd1,   8'h05};
        vecs[11] = '{8'd255, 8'd1,   8'hFF};
        vecs[12] = '{8'd17,  8'd15,  8'hFF};

        rst_n = 1'b0;
        in_valid = 1'b0;
        in_a = '0;
        in_b = '0;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_in_ready", int'(in_ready), 1);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_out_p", int'(out_p), 0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 13; i++)
            do_op(vecs[i].a, vecs[i].b, vecs[i].p, i % 3);

        // Backpressure with a new request held during DONE.
        out_ready = 1'b0;
        start_and_run(8'd9, 8'd9, n);
        check("bp_busy_cycles", n, exp_busy(8'd9));
        in_valid = 1'b1;
        in_a = 8'd3;
        in_b = 8'd5;
        repeat (5) begin
            check("bp_valid", int'(out_valid), 1);
            check("bp_p", int'(out_p), 8'h51);
            check("bp_in_ready", int'(in_ready), 0);
            check("bp_not_busy", int'(busy), 0);
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        check("bp_handoff_valid", int'(out_valid), 0);
        check("bp_handoff_in_ready", int'(in_ready), 1);
        out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        check("bp_next_busy", int'(busy), 1);
        n = 1;
        while (busy && n < 64) begin
            @(negedge clk);
            if (busy) n++;
        end
        check("bp_next_cycles", n, exp_busy(8'd5));
        check("bp_next_p", int'(out_p), 8'h0F);
        check("bp_next_valid", int'(out_valid), 1);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;

        // Reset during BUSY aborts the operation.
        wait_ready();
        in_valid = 1'b1;
        in_a = 8'd7;
        in_b = 8'd9;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("pre_rst_busy", int'(busy), 1);
        rst_n = 1'b0;
        #1;
        check("midrst_in_ready", int'(in_ready), 1);
        check("midrst_out_valid", int'(out_valid), 0);
        check("midrst_busy", int'(busy), 0);
        check("midrst_out_p", int'(out_p), 0);
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        repeat (12) begin
            @(negedge clk);
            check("postrst_no_valid", int'(out_valid), 0);
        end
        do_op(8'd7, 8'd9, 8'h3F, 0);

        for (int i = 0; i < 500; i++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            if (i % 50 == 0) rb = '0;
            rp = W'(ra * rb);
            do_op(ra, rb, rp, int'($urandom_range(0, 3)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
